rr_arbiter_4_dec: RTL and testbench

//   Four-requester round-robin arbiter that shares one resource among four masters.

---
 rtl/rr_arbiter_4_dec.sv | 132 +++++++++++++
 tb/tb_rr_arbiter_4_dec.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4_dec.sv
// rr_arbiter_4_dec
//   Round-robin arbiter for four requesters sharing one resource. It drives a
//   2x4 decoder through grant_id/grant_valid and also provides the decoded
//   one-hot grant directly. All outputs are registered.
//
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   req[3:0]     level-sensitive requests, bit i = requester i
//   grant[3:0]   one-hot grant, zero when idle
//   grant_id     encoded grant index (decoder select)
//   grant_valid  grant active (decoder enable)
//   timeout      one-cycle pulse when a grant is cut off by MAX_HOLD
//
//   MAX_HOLD     maximum cycles a single grant may last, 0 = unlimited
//   CNT_W        hold counter width, 2**CNT_W > MAX_HOLD
module rr_arbiter_4_dec #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Compare value for the hold counter; the counter starts at 0 on the first
  // granted cycle, so MAX_HOLD-1 marks the last cycle allowed.
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       id_nxt;
  logic             valid_nxt, to_nxt;

  logic [7:0]       req2;
  logic [3:0]       rot;
  logic [1:0]       ofs, sel;
  logic             any_req, own_req, limit_hit, release_now;

  // Rotate requests so the pointer position sits at bit 0, take the lowest
  // set bit, then add the pointer back to get the absolute index.
  assign req2    = {req, req} >> ptr;
  assign rot     = req2[3:0];
  assign any_req = |req;

  always_comb begin
    ofs = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (rot[i]) ofs = 2'(i);
  end

  assign sel         = ptr + ofs;
  assign own_req     = req[grant_id];
  assign limit_hit   = (MAX_HOLD != 0) && (hold_cnt == LIM);
  // A dropped request wins over the limit, so timeout only fires when the
  // owner is still requesting.
  assign release_now = !own_req || limit_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      grant       <= 4'b0000;
      grant_id    <= 2'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= cnt_nxt;
      grant       <= grant_nxt;
      grant_id    <= id_nxt;
      grant_valid <= valid_nxt;
      timeout     <= to_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    grant_nxt = grant;
    id_nxt    = grant_id;
    valid_nxt = grant_valid;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          id_nxt    = sel;
          grant_nxt = 4'(4'b0001 << sel);
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // grant_id is left as is; grant_valid low disables the decoder
          grant_nxt = 4'b0000;
          valid_nxt = 1'b0;
          ptr_nxt   = grant_id + 2'd1;
          to_nxt    = own_req;
        end else if (hold_cnt != '1) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        grant_nxt = 4'b0000;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_4_dec.sv
// Bench for rr_arbiter_4_dec: three instances (MAX_HOLD 8, 4, 0) share the
// same stimulus. A cycle-level model tracks owner / cycles held / pointer
// for each and is compared after every clock; directed vectors and
// sequences cover reset, latency, round robin, no-preemption and timeouts.
module tb_rr_arbiter_4_dec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt [3];
  logic [1:0] gid [3];
  logic       gv  [3];
  logic       gto [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter_4_dec u8 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(gnt[0]), .grant_id(gid[0]),
    .grant_valid(gv[0]), .timeout(gto[0]));

  rr_arbiter_4_dec #(.MAX_HOLD(4), .CNT_W(3)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(gnt[1]), .grant_id(gid[1]),
    .grant_valid(gv[1]), .timeout(gto[1]));

  rr_arbiter_4_dec #(.MAX_HOLD(0), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(gnt[2]), .grant_id(gid[2]),
    .grant_valid(gv[2]), .timeout(gto[2]));

  // Reference: owner = -1 when idle, held = cycles the grant has been visible
  typedef struct {
    int owner;
    int held;
    int ptr;
    bit to;
  } mdl_t;

  mdl_t m [3];
  int   mh [3] = '{8, 4, 0};

  function automatic mdl_t step(mdl_t s, int max, bit rst, logic [3:0] r);
    mdl_t n = s;
    n.to = 0;
    if (!rst) begin
      n.owner = -1; n.held = 0; n.ptr = 0;
    end else if (s.owner < 0) begin
      for (int k = 3; k >= 0; k--)
        if (r[(s.ptr + k) % 4]) n.owner = (s.ptr + k) % 4;
      n.held = 1;
    end else if (!r[s.owner]) begin
      n.ptr = (s.owner + 1) % 4; n.owner = -1;
    end else if (max != 0 && s.held >= max) begin
      n.ptr = (s.owner + 1) % 4; n.owner = -1; n.to = 1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    logic [3:0] dec;
    for (int k = 0; k < 3; k++) begin
      eg = (m[k].owner < 0) ? 4'b0000 : 4'(4'b0001 << m[k].owner);
      chk($sformatf("model_%0d", k), {gnt[k], gv[k], gto[k]},
          {eg, m[k].owner >= 0, m[k].to});
      if (m[k].owner >= 0)
        chk($sformatf("model_id_%0d", k), 32'(gid[k]), 32'(m[k].owner));
      dec = gv[k] ? 4'(4'b0001 << gid[k]) : 4'b0000;
      chk($sformatf("invariant_%0d", k), {gnt[k], gto[k] & gv[k]}, {dec, 1'b0});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = step(m[k], mh[k], rst_n, req);
    #1;
    check_all();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] g;
    bit         v;
    bit         to;
  } vec_t;

  vec_t tbl [$];
  logic [3:0] e;

  initial begin
    for (int k = 0; k < 3; k++) m[k] = '{owner: -1, held: 0, ptr: 0, to: 0};
    rst_n = 1'b0;
    req   = 4'b0000;

    // Directed vectors for the MAX_HOLD=8 instance
    tbl.push_back('{0, 4'b1111, 4'b0000, 0, 0});
    tbl.push_back('{0, 4'b1111, 4'b0000, 0, 0});
    tbl.push_back('{1, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{1, 4'b0100, 4'b0100, 1, 0});
    tbl.push_back('{1, 4'b0100, 4'b0100, 1, 0});
    tbl.push_back('{1, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{1, 4'b1001, 4'b1000, 1, 0});
    tbl.push_back('{1, 4'b1001, 4'b1000, 1, 0});
    tbl.push_back('{1, 4'b1001, 4'b1000, 1, 0});
    tbl.push_back('{1, 4'b0001, 4'b0000, 0, 0});
    tbl.push_back('{1, 4'b0001, 4'b0001, 1, 0});
    tbl.push_back('{1, 4'b0000, 4'b0000, 0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst;
      req   = tbl[i].req;
      tick();
      chk($sformatf("vec_%0d", i), {gnt[0], gv[0], gto[0]},
          {tbl[i].g, tbl[i].v, tbl[i].to});
    end

    // Round robin with MAX_HOLD=4: four granted cycles then a timeout cycle
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rr_grant", {gnt[1], gv[1], gto[1]}, {e, 1'b1, 1'b0});
      end
      tick();
      chk("rr_dead", {gnt[1], gv[1], gto[1]}, {4'b0000, 1'b0, 1'b1});
    end

    // Reset mid-grant, then the pointer is back at 0
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0010; tick();
    chk("pre_reset_grant", 32'(gnt[1]), 32'(4'b0010));
    rst_n = 1'b0; tick();
    chk("reset_drop", {gnt[0], gnt[1], gnt[2], gv[0], gv[1], gv[2]}, 18'd0);
    rst_n = 1'b1; req = 4'b1111; tick();
    chk("post_reset_ptr", 32'(gnt[0]), 32'(4'b0001));

    // Unlimited hold: grant never released, no timeout
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("nolimit_hold", {gnt[2], gto[2]}, {4'b0001, 1'b0});
    end

    // Random traffic against the model
    req = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(99) != 0);
      if ($urandom_range(3) == 0) req = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
